// File: rtl/uart_fifo_periph.sv
// Memory-mapped full-duplex UART: TX/RX byte FIFOs, programmable baud divisor,
// and sticky error flags behind a four-word register window.
module uart_fifo_periph #(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD_RATE   = 115200,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sel,
    input  logic [1:0]  i_reg,
    input  logic        i_rstrb,
    input  logic        i_wstrb,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic        i_rxd,
    output logic        o_txd,
    output logic        o_irq
);

    localparam int          DIV_CALC = CLK_FREQ_HZ / BAUD_RATE;
    localparam logic [15:0] DIV_RST  = (DIV_CALC < 4) ? 16'd4 : 16'(DIV_CALC);
    localparam int          TAW      = $clog2(TX_DEPTH);
    localparam int          RAW      = $clog2(RX_DEPTH);

    // Bus strobes are single-cycle and qualified by i_sel; there is no
    // back-pressure, so every selected strobe is an access on that edge.
    logic wr_data, wr_status, wr_div, rd_data;
    assign wr_data   = i_sel & i_wstrb & (i_reg == 2'd0);
    assign wr_status = i_sel & i_wstrb & (i_reg == 2'd1);
    assign wr_div    = i_sel & i_wstrb & (i_reg == 2'd2);
    assign rd_data   = i_sel & i_rstrb & (i_reg == 2'd0);

    logic unused_wdata;
    assign unused_wdata = ^i_wdata[31:16];

    logic [15:0] div_reg;
    logic        rx_overrun, frame_err, tx_drop;

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [TAW:0]   tx_cnt;
    logic           tx_empty, tx_full, tx_pop, tx_push, tx_drop_set;

    assign tx_empty    = (tx_cnt == '0);
    assign tx_full     = (tx_cnt == (TAW+1)'(TX_DEPTH));
    assign tx_push     = wr_data & (~tx_full | tx_pop);
    assign tx_drop_set = wr_data & tx_full & ~tx_pop;

    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[tx_wp] <= i_wdata[7:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TAW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + (TAW+1)'(1);
                2'b01:   tx_cnt <= tx_cnt - (TAW+1)'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t   tx_state, tx_state_d;
    logic [7:0]  tx_sh, tx_sh_d;
    logic [15:0] tx_tmr, tx_tmr_d, tx_div, tx_div_d;
    logic [2:0]  tx_bit, tx_bit_d;
    logic        txd_d;

    always_comb begin
        tx_state_d = tx_state;
        tx_sh_d    = tx_sh;
        tx_tmr_d   = tx_tmr;
        tx_div_d   = tx_div;
        tx_bit_d   = tx_bit;
        txd_d      = o_txd;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                    tx_sh_d    = tx_mem[tx_rp];
                    tx_div_d   = div_reg;
                    tx_tmr_d   = div_reg - 16'd1;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_tmr == 16'd0) begin
                    tx_state_d = TX_DATA;
                    tx_tmr_d   = tx_div - 16'd1;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_sh[0];
                end else begin
                    tx_tmr_d = tx_tmr - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_tmr == 16'd0) begin
                    tx_tmr_d = tx_div - 16'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh[7:1]};
                        txd_d    = tx_sh[1];
                    end
                end else begin
                    tx_tmr_d = tx_tmr - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_tmr == 16'd0) begin
                    // Back-to-back frames: next start bit follows the stop bit directly.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_d = TX_START;
                        tx_sh_d    = tx_mem[tx_rp];
                        tx_div_d   = div_reg;
                        tx_tmr_d   = div_reg - 16'd1;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_tmr_d = tx_tmr - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '0;
            tx_tmr   <= '0;
            tx_div   <= DIV_RST;
            tx_bit   <= '0;
            o_txd    <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_sh    <= tx_sh_d;
            tx_tmr   <= tx_tmr_d;
            tx_div   <= tx_div_d;
            tx_bit   <= tx_bit_d;
            o_txd    <= txd_d;
        end
    end

    // ---------------- RX synchronizer + FSM ----------------
    logic rx_s1, rx_s2, rx_prev;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= i_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    rx_state_t   rx_state, rx_state_d;
    logic [7:0]  rx_sh, rx_sh_d;
    logic [15:0] rx_tmr, rx_tmr_d, rx_div, rx_div_d;
    logic [2:0]  rx_bit, rx_bit_d;
    logic        rx_done, frame_set;

    always_comb begin
        rx_state_d = rx_state;
        rx_sh_d    = rx_sh;
        rx_tmr_d   = rx_tmr;
        rx_div_d   = rx_div;
        rx_bit_d   = rx_bit;
        rx_done    = 1'b0;
        frame_set  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_state_d = RX_START;
                    rx_div_d   = div_reg;
                    rx_tmr_d   = (div_reg >> 1) - 16'd1;
                end
            end
            RX_START: begin
                if (rx_tmr == 16'd0) begin
                    rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
                    rx_tmr_d   = rx_div - 16'd1;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_tmr_d = rx_tmr - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_tmr == 16'd0) begin
                    rx_sh_d  = {rx_s2, rx_sh[7:1]};
                    rx_tmr_d = rx_div - 16'd1;
                    if (rx_bit == 3'd7) rx_state_d = RX_STOP;
                    else                rx_bit_d   = rx_bit + 3'd1;
                end else begin
                    rx_tmr_d = rx_tmr - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_tmr == 16'd0) begin
                    if (rx_s2) begin
                        rx_done    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_tmr_d = rx_tmr - 16'd1;
                end
            end
            RX_WAIT_HIGH: if (rx_s2) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_state <= RX_IDLE;
            rx_sh    <= '0;
            rx_tmr   <= '0;
            rx_div   <= DIV_RST;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_d;
            rx_sh    <= rx_sh_d;
            rx_tmr   <= rx_tmr_d;
            rx_div   <= rx_div_d;
            rx_bit   <= rx_bit_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [RAW:0]   rx_cnt;
    logic           rx_empty, rx_full, rx_pop, rx_push, overrun_set;

    assign rx_empty    = (rx_cnt == '0);
    assign rx_full     = (rx_cnt == (RAW+1)'(RX_DEPTH));
    assign rx_pop      = rd_data & ~rx_empty;
    assign rx_push     = rx_done & (~rx_full | rx_pop);
    assign overrun_set = rx_done & rx_full & ~rx_pop;

    always_ff @(posedge i_clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RAW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + (RAW+1)'(1);
                2'b01:   rx_cnt <= rx_cnt - (RAW+1)'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // ---------------- registers, flags, read mux ----------------
    logic        tx_idle;
    logic [31:0] status, rd_mux;
    assign tx_idle = tx_empty & (tx_state == TX_IDLE);
    assign status  = {22'd0, tx_full, 3'd0, tx_drop, frame_err, rx_overrun,
                      tx_idle, tx_full, ~rx_empty};

    always_comb begin
        rd_mux = 32'd0;
        if (i_sel) begin
            case (i_reg)
                2'd0:    rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
                2'd1:    rd_mux = status;
                2'd2:    rd_mux = {16'd0, div_reg};
                default: rd_mux = 32'd0;
            endcase
        end
    end

    // A new error event in the same cycle as its W1C keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata    <= 32'd0;
            div_reg    <= DIV_RST;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (i_rstrb) o_rdata <= rd_mux;
            if (wr_div)  div_reg <= (i_wdata[15:0] < 16'd4) ? 16'd4 : i_wdata[15:0];
            rx_overrun <= (rx_overrun & ~(wr_status & i_wdata[3])) | overrun_set;
            frame_err  <= (frame_err  & ~(wr_status & i_wdata[4])) | frame_set;
            tx_drop    <= (tx_drop    & ~(wr_status & i_wdata[5])) | tx_drop_set;
        end
    end

    assign o_irq = ~rx_empty | rx_overrun | frame_err | tx_drop;

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Bench for uart_fifo_periph: directed scenarios plus randomized loopback
// traffic, checked against queue-based TX/RX models and a frame-level line monitor.
module tb_uart_fifo_periph;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, sel, rstrb, wstrb;
    logic [1:0]  regsel;
    logic [31:0] wdata, rdata;
    logic        rxd, txd, irq;
    logic        rxd_drv, loopback;

    assign rxd = loopback ? txd : rxd_drv;

    uart_fifo_periph #(
        .CLK_FREQ_HZ(1000), .BAUD_RATE(100), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_reg(regsel),
        .i_rstrb(rstrb), .i_wstrb(wstrb), .i_wdata(wdata), .o_rdata(rdata),
        .i_rxd(rxd), .o_txd(txd), .o_irq(irq)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        sel = 1'b1; wstrb = 1'b1; regsel = r; wdata = d;
        cyc();
        sel = 1'b0; wstrb = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        sel = 1'b1; rstrb = 1'b1; regsel = r;
        cyc();
        sel = 1'b0; rstrb = 1'b0;
        d = rdata;
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd_drv = bits[k];
            cyc(div);
        end
        rxd_drv = 1'b1;
    endtask

    // Line monitor: frames must start within first_wait cycles, follow each
    // other with no gap, and hold every bit for exactly div cycles.
    task automatic mon_frames(input int n, input int div, input int first_wait);
        int waited, limit, unstable;
        logic [9:0] got;
        logic [7:0] e;
        for (int f = 0; f < n; f++) begin
            limit  = (f == 0) ? first_wait : 0;
            waited = 0;
            while (txd !== 1'b0 && waited <= limit) begin
                cyc();
                waited++;
            end
            if (waited > limit) begin
                check("tx_start_timeout", waited, limit);
                return;
            end
            if (f == 0) check("tx_start_latency_ok", waited <= first_wait, 1);
            else        check("tx_gap", waited, 0);
            unstable = 0;
            got = '0;
            for (int j = 0; j < 10 * div; j++) begin
                if (j % div == 0) got[j / div] = txd;
                else if (txd !== got[j / div]) unstable++;
                cyc();
            end
            check("tx_exp_avail", tx_exp_q.size() != 0, 1);
            e = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 8'h00;
            check("tx_frame", got, {1'b1, e, 1'b0});
            check("tx_bit_stable", unstable, 0);
            if (loopback) rx_exp_q.push_back(e);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] d;
    logic [7:0]  b, e;
    logic        overrun;
    int          n, div;

    initial begin
        rst = 1'b1; sel = 1'b0; rstrb = 1'b0; wstrb = 1'b0; regsel = 2'd0;
        wdata = 32'd0; rxd_drv = 1'b1; loopback = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc();

        // Reset state
        check("rst_txd", txd, 1);
        check("rst_irq", irq, 0);
        check("rst_rdata", rdata, 0);
        bus_read(2'd1, d); check("rst_status", d, 32'h004);
        bus_read(2'd2, d); check("rst_div", d, DIV);

        // Single byte 0x55 in loopback
        d = $urandom();
        d[7:0] = 8'h55;
        tx_exp_q.push_back(8'h55);
        bus_write(2'd0, d);
        mon_frames(1, DIV, 2);
        cyc(3);
        bus_read(2'd1, d); check("t2_status", d, 32'h005);
        check("t2_irq", irq, 1);
        e = rx_exp_q.pop_front();
        bus_read(2'd0, d); check("t2_rx_data", d, {24'd0, e});
        bus_read(2'd0, d); check("t2_rx_empty_read", d, 0);

        // Six back-to-back writes, loopback cut: five accepted, one dropped
        loopback = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    b = 8'($urandom());
                    if (i < DEPTH + 1) tx_exp_q.push_back(b);
                    bus_write(2'd0, {24'd0, b});
                end
                bus_read(2'd1, d); check("t3_status_full", d, 32'h222);
            end
            mon_frames(DEPTH + 1, DIV, 3);
        join
        check("t3_tx_q_drained", tx_exp_q.size(), 0);
        bus_read(2'd1, d); check("t3_status_drop", d, 32'h024);
        check("t3_irq_drop", irq, 1);
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, d); check("t3_status_w1c", d, 32'h004);
        check("t3_irq_clear", irq, 0);

        // Five received frames, no reads: overrun on the fifth
        overrun = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom());
            if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
            else overrun = 1'b1;
            drive_rx(b, 1'b1, DIV);
            cyc($urandom_range(0, 3));
        end
        cyc(5);
        bus_read(2'd1, d);
        check("t4_status", d, 32'h005 | (overrun ? 32'h008 : 32'h000));
        check("t4_irq", irq, 1);
        for (int i = 0; i < DEPTH; i++) begin
            e = rx_exp_q.pop_front();
            bus_read(2'd0, d); check("t4_rx_data", d, {24'd0, e});
        end
        bus_read(2'd0, d); check("t4_rx_empty_read", d, 0);
        bus_write(2'd1, 32'h08);
        bus_read(2'd1, d); check("t4_status_w1c", d, 32'h004);

        // Bad stop bit, then a short low glitch
        drive_rx(8'($urandom()), 1'b0, DIV);
        cyc(2 * DIV);
        rxd_drv = 1'b0;
        cyc(3);
        rxd_drv = 1'b1;
        cyc(3 * DIV);
        bus_read(2'd1, d); check("t5_status", d, 32'h014);
        check("t5_irq", irq, 1);
        bus_read(2'd0, d); check("t5_no_byte", d, 0);
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, d); check("t5_status_w1c", d, 32'h004);

        // Randomized loopback traffic at random divisors
        loopback = 1'b1;
        for (int it = 0; it < 4; it++) begin
            div = $urandom_range(4, 14);
            bus_write(2'd2, div);
            bus_read(2'd2, d); check("rnd_div", d, div);
            n = $urandom_range(1, 3);
            fork
                begin
                    for (int i = 0; i < n; i++) begin
                        b = 8'($urandom());
                        tx_exp_q.push_back(b);
                        bus_write(2'd0, {8'($urandom()), 16'd0, b});
                    end
                end
                mon_frames(n, div, 3);
            join
            cyc(4);
            bus_read(2'd1, d); check("rnd_status", d, 32'h005);
            for (int i = 0; i < n; i++) begin
                e = rx_exp_q.pop_front();
                bus_read(2'd0, d); check("rnd_rx_data", d, {24'd0, e});
            end
        end

        // Divisor clamp, then reset in the middle of a frame
        bus_write(2'd2, 32'd2);
        bus_read(2'd2, d); check("t6_div_clamp", d, 4);
        bus_write(2'd2, $urandom_range(0, 3));
        bus_read(2'd2, d); check("t6_div_clamp_rnd", d, 4);
        bus_write(2'd0, {24'd0, 8'h00});
        bus_write(2'd0, {24'd0, 8'($urandom())});
        cyc(5);
        check("t6_txd_in_frame", txd, 0);
        rst = 1'b1;
        cyc();
        check("t6_txd_after_rst", txd, 1);
        rst = 1'b0;
        tx_exp_q.delete();
        rx_exp_q.delete();
        cyc();
        check("t6_irq", irq, 0);
        check("t6_rdata", rdata, 0);
        bus_read(2'd1, d); check("t6_status", d, 32'h004);
        bus_read(2'd2, d); check("t6_div", d, DIV);
        cyc(12 * DIV);
        check("t6_txd_idle", txd, 1);
        bus_read(2'd1, d); check("t6_status_late", d, 32'h004);
        bus_read(2'd0, d); check("t6_rx_empty", d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
